// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit living beside the ALU in EX.
// Multiply is radix-2 shift-add on magnitudes; divide is restoring, one
// quotient bit per cycle. Signs are stripped at accept and reapplied at the end.
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_t r_state;
  state_t w_nextState;

  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_mcand;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_rem;
  logic              r_negRes;
  logic              r_negRem;
  logic [XLEN-1:0]   r_result;

  logic              w_aSigned;
  logic              w_bSigned;
  logic              w_aNeg;
  logic              w_bNeg;
  logic [XLEN-1:0]   w_absA;
  logic [XLEN-1:0]   w_absB;
  logic              w_divByZero;
  logic              w_overflow;
  logic              w_special;
  logic [XLEN-1:0]   w_specialRes;
  logic              w_lastIter;

  logic [2*XLEN-1:0] w_accNext;
  logic [XLEN:0]     w_remShift;
  logic [XLEN:0]     w_trial;
  logic [XLEN-1:0]   w_remNext;
  logic [XLEN-1:0]   w_quoNext;
  logic [2*XLEN-1:0] w_prodFinal;
  logic [XLEN-1:0]   w_quoFinal;
  logic [XLEN-1:0]   w_remFinal;
  logic [XLEN-1:0]   w_finalRes;

  // Operand signedness, magnitudes and early-out divide cases seen at accept
  always_comb begin
    w_aSigned    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                   (op == OP_DIV) || (op == OP_REM);
    w_bSigned    = (op == OP_MUL) || (op == OP_MULH) ||
                   (op == OP_DIV) || (op == OP_REM);
    w_aNeg       = w_aSigned && a[XLEN-1];
    w_bNeg       = w_bSigned && b[XLEN-1];
    w_absA       = w_aNeg ? (~a + 1'b1) : a;
    w_absB       = w_bNeg ? (~b + 1'b1) : b;
    w_divByZero  = op[2] && (b == '0);
    w_overflow   = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
    w_special    = w_divByZero || w_overflow;
    w_specialRes = '0;
    if (w_divByZero) begin
      w_specialRes = op[1] ? a : '1;
    end else if (w_overflow) begin
      w_specialRes = op[1] ? '0 : MIN_NEG;
    end
  end

  // One shift-add or restoring-divide step plus the sign-corrected final value
  always_comb begin
    w_accNext   = r_a[0] ? (r_acc + r_mcand) : r_acc;
    w_remShift  = {r_rem, r_a[XLEN-1]};
    w_trial     = w_remShift - {1'b0, r_b};
    w_remNext   = w_trial[XLEN] ? w_remShift[XLEN-1:0] : w_trial[XLEN-1:0];
    w_quoNext   = {r_a[XLEN-2:0], ~w_trial[XLEN]};
    w_prodFinal = r_negRes ? (~w_accNext + 1'b1) : w_accNext;
    w_quoFinal  = r_negRes ? (~w_quoNext + 1'b1) : w_quoNext;
    w_remFinal  = r_negRem ? (~w_remNext + 1'b1) : w_remNext;
    w_lastIter  = (r_cnt == LAST_CNT);
    if (r_op[2]) begin
      w_finalRes = r_op[1] ? w_remFinal : w_quoFinal;
    end else if (r_op[1:0] == 2'b00) begin
      w_finalRes = w_prodFinal[XLEN-1:0];
    end else begin
      w_finalRes = w_prodFinal[2*XLEN-1:XLEN];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: flush always wins, special divides skip straight to DONE
  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid)   w_nextState = w_special ? DONE : CALC;
        CALC:    if (w_lastIter) w_nextState = DONE;
        DONE:    if (out_ready)  w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    result    = r_result;
  end

  // Datapath: latch magnitudes on accept, iterate in CALC, load result at the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_result <= '0;
    end else if (!flush) begin
      if (r_state == IDLE && in_valid) begin
        r_cnt    <= '0;
        r_op     <= op;
        r_a      <= w_absA;
        r_b      <= w_absB;
        r_mcand  <= {{XLEN{1'b0}}, w_absB};
        r_acc    <= '0;
        r_rem    <= '0;
        r_negRes <= w_aNeg ^ w_bNeg;
        r_negRem <= w_aNeg;
        if (w_special) begin
          r_result <= w_specialRes;
        end
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_op[2]) begin
          r_a   <= w_quoNext;
          r_rem <= w_remNext;
        end else begin
          r_acc   <= w_accNext;
          r_a     <= r_a >> 1;
          r_mcand <= r_mcand << 1;
        end
        if (w_lastIter) begin
          r_result <= w_finalRes;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed checks of the iterative multiply/divide unit.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present one request for a single edge, then scramble the operands
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    @(negedge clk);
    in_valid = 1'b0;
    op       = 3'($urandom_range(0, 7));
    a        = $urandom;
    b        = $urandom;
  endtask

  // Wait for out_valid with a bound; returns cycles waited after the accept
  task automatic waitDone(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    checkOutput({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] expRes, input int expLat);
    int n;
    applyStimulus(o, x, y);
    waitDone(n);
    checkOutput({tag, "_latency"}, 32'(n), 32'(expLat));
    checkOutput({tag, "_result"}, result, expRes);
    consume(tag);
  endtask

  initial begin
    int          n;
    logic        sawValid;
    logic [31:0] heldRes;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 3'b000;
    a         = 32'h0;
    b         = 32'h0;

    #12;
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset in the middle of a calculation
    applyStimulus(3'b000, 32'h0000_0003, 32'h0000_0007);
    repeat (9) @(negedge clk);
    checkOutput("midcalc_busy", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("after_rst_mul", 3'b000, 32'h0000_0003, 32'h0000_0007, 32'h0000_0015, 32);

    // Multiplies
    runOp("mul_m1x5",     3'b000, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFB, 32);
    runOp("mulh_m1x5",    3'b001, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32);
    runOp("mulhu_m1x5",   3'b011, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0004, 32);
    runOp("mulhsu_m1x80", 3'b010, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32);

    // Divides
    runOp("div_m7d2",  3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32);
    runOp("rem_m7d2",  3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32);
    runOp("divu_7d2",  3'b101, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 32);
    runOp("remu_7d2",  3'b111, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32);
    runOp("div_b1",    3'b100, 32'h0000_1234, 32'h0000_0001, 32'h0000_1234, 32);

    // Special divide cases finish one cycle after accept
    runOp("div_by0",   3'b100, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 0);
    runOp("rem_by0",   3'b110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 0);
    runOp("divu_by0",  3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 0);
    runOp("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    runOp("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

    // Backpressure: result holds while out_ready is low, new requests ignored
    applyStimulus(3'b000, 32'h0000_0010, 32'h0000_0010);
    waitDone(n);
    checkOutput("bp_latency", 32'(n), 32'd32);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op       = 3'b101;
      a        = 32'h0000_0009;
      b        = 32'h0000_0000;
      @(negedge clk);
      checkOutput("bp_hold_result", result, 32'h0000_0100);
      checkOutput("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("bp_release_out_valid", {31'b0, out_valid}, 32'd0);

    // Flush in the same cycle as a request: nothing is accepted
    in_valid = 1'b1;
    flush    = 1'b1;
    op       = 3'b100;
    a        = 32'h0000_0001;
    b        = 32'h0000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    checkOutput("flush_accept_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("flush_accept_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("flush_accept_result", result, 32'h0000_0100);

    // Flush mid-calculation: back to idle, no result produced
    heldRes = result;
    applyStimulus(3'b011, 32'h0000_1000, 32'h0000_1000);
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("flush_no_valid", {31'b0, sawValid}, 32'd0);
    checkOutput("flush_result_kept", result, heldRes);
    runOp("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit for the multi-cycle datapath.
- Handles the ops the single-cycle ALU cannot: it sits beside the ALU in EX and takes operands and funct3 from the decoder.
- Valid/ready handshake on the input and output sides; the pipeline stalls EX while the unit is busy.
- Multiply is radix-2 shift-add; divide is restoring, one bit per cycle.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort of any in-flight op
in_valid  input  1  request valid
in_ready  output  1  unit idle, may accept
op  input  3  funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
a  input  32  rs1 value
b  input  32  rs2 value
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  32  registered result

Behaviour:
- Reset (rst_n low, async): state IDLE, counter 0, result 0, out_valid 0, in_ready 1, all internal registers 0.
- States: IDLE, CALC, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- Accept: in_valid && in_ready at edge E0. At that edge:
  - latch op;
  - latch |a|, |b| per op signedness;
  - latch result sign flags;
  - clear the counter.
- Signedness:
  - mul/mulh/div/rem: a and b are signed.
  - mulhsu: a signed, b unsigned.
  - mulhu/divu/remu: both unsigned.
- Special divide cases are detected at accept and go directly to DONE at E0 with result loaded:
  - b==0: div/divu gives 0xFFFFFFFF; rem/remu gives a.
  - Signed overflow (div/rem with a==0x80000000, b==0xFFFFFFFF): div gives 0x80000000; rem gives 0.
- CALC: one iteration per edge, E1..E32.
  - Multiply: 64-bit accumulator; add the shifted multiplicand when the current multiplier bit is 1.
  - Divide: shift the remainder left by one and bring in the dividend MSB; trial subtract the divisor; keep the result if non-negative; the quotient bit is the inverse borrow.
- At E32 the state moves to DONE and result is loaded with the sign-corrected value:
  - mul: low 32 bits of the product.
  - mulh/mulhsu/mulhu: high 32 bits.
  - Product negated (two's complement, 64-bit) when the operand signs differ.
  - Quotient negated when the operand signs differ.
  - Remainder takes the sign of a.
- Latency: out_valid is high in the cycle after E32 (32 cycles after acceptance); 1 cycle for special cases.
- DONE: result and out_valid hold stable until out_valid && out_ready. At that edge the state returns to IDLE; a new op cannot be accepted in the same cycle.
- Back-to-back throughput: 1 op per 34 cycles with out_ready tied high.
- flush:
  - At the next edge the state goes to IDLE and out_valid drops.
  - result keeps its old value; no output is produced for the aborted op.
  - flush overrides accept in the same cycle: no op is latched.
- The inputs a, b and op are don't-care after acceptance; the unit computes only from latched copies.
- rst_n asserted mid-CALC aborts the op immediately (async); after release the unit is in IDLE.
- a==b, a==0, and b==1 take the normal 32-iteration path; there is no early termination.

Test Plan:
- Reset while in CALC (pulse rst_n low at cycle 10) -> out_valid 0 and in_ready 1 immediately; a later op completes correctly.
- mul a=0xFFFFFFFF (-1), b=5 -> 0xFFFFFFFB after 32 cycles.
  - Same operands with mulh -> 0xFFFFFFFF.
  - Same operands with mulhu -> 0x00000004.
  - mulhsu a=-1, b=0x80000000 -> 0xFFFFFFFF.
- div a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD.
  - rem with the same operands -> 0xFFFFFFFF.
  - divu a=7, b=2 -> 3; remu with the same operands -> 1.
- Special cases:
  - div a=0x1234, b=0 -> 0xFFFFFFFF in 1 cycle.
  - rem a=0x1234, b=0 -> 0x1234.
  - div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem with the same operands -> 0.
- Backpressure: hold out_ready low for 5 cycles after DONE -> result and out_valid stable, in_ready 0, new in_valid ignored; one cycle after out_ready goes high, in_ready=1.
- Assert flush at CALC cycle 15 -> IDLE next edge, no out_valid; a following mulhu 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
